mix_round_engine: RTL

- Parametrised, handshaked successor to the fixed 8 x 32-bit posedge mixing datapath.
- Generalised in lane count, word width and round count.
- Loads a seed vector, applies a 7-stage mixing round R times (one stage per clock), then presents the result.
- Sits behind a valid/ready producer as the design's hash/whitening workload generator.

---
 rtl/mix_pkg.sv | 31 +++
 rtl/mix_stage.sv | 46 ++++
 rtl/mix_round_engine.sv | 108 ++++++++++
 3 files changed

// File: rtl/mix_pkg.sv
// Shared types, constant tables and lane-index helper for the mixing round engine.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } stage_e;

  // Per-lane multiplier and addend used by the final stage, indexed by lane mod 8.
  localparam int MUL [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  localparam int ADD [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

  // Lane index i+off wrapped into 0..lanes-1; off may be negative.
  function automatic int lane_idx(input int i, input int off, input int lanes);
    return (((i + off) % lanes) + lanes) % lanes;
  endfunction

endpackage

// File: rtl/mix_stage.sv
// One mixing stage applied to the whole lane vector, lanes updated in order 0..LANES-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module mix_stage
  import mix_pkg::*;
#(
  parameter int LANES = 8,
  parameter int W     = 32,
  parameter int SHA   = 17,
  parameter int SHB   = 12
) (
  input  logic [LANES*W-1:0] lanes_in,
  input  stage_e             stage,
  output logic [LANES*W-1:0] lanes_out
);

  localparam int H = W / 2;
  localparam int Q = LANES / 2;

  logic [W-1:0] x [LANES];

  // Sequential in-place update so lane i observes lanes below it already updated.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      x[i] = lanes_in[i*W +: W];
    end
    for (int i = 0; i < LANES; i++) begin
      case (stage)
        S0: x[i] = x[i] + W'(i);
        S1: x[i] = x[i] + x[lane_idx(i, -1, LANES)];
        S2: x[i] = x[i] + x[lane_idx(i, 1, LANES)] - x[lane_idx(i, Q + 1, LANES)];
        S3: x[i] = x[i] ^ (x[lane_idx(i, 3, LANES)] << H);
        S4: x[i] = x[i] - (x[lane_idx(i, 2, LANES)] >> SHA)
                        + (x[lane_idx(i, 4, LANES)] >> SHB);
        S5: x[i] = x[i] + x[lane_idx(i, -1, LANES)] - x[lane_idx(i, -2, LANES)];
        S6: x[i] = x[i] * W'(MUL[i % 8]) + W'(ADD[i % 8]);
        default: x[i] = x[i];
      endcase
    end
    lanes_out = '0;
    for (int i = 0; i < LANES; i++) begin
      lanes_out[i*W +: W] = x[i];
    end
  end

endmodule

// File: rtl/mix_round_engine.sv
// Loads a seed, runs R seven-stage mixing rounds (one stage per clock), presents the result.
// Latency: accept at edge t -> out_valid after edge t+7R (R==0: after edge t).
// Backpressure: result held in DONE until out_ready; no new job accepted outside IDLE.
module mix_round_engine
  import mix_pkg::*;
#(
  parameter int LANES = 8,
  parameter int W     = 32,
  parameter int RW    = 8,
  parameter int SHA   = 17,
  parameter int SHB   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_seed,
  input  logic [RW-1:0]      in_rounds,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               busy,
  output logic [RW-1:0]      round_cnt
);

  state_e             state_q, state_d;
  stage_e             stage_q, stage_d;
  logic [LANES*W-1:0] lanes_q, lanes_d, mixed;
  logic [RW-1:0]      rounds_q, rounds_d;
  logic [RW-1:0]      cnt_q, cnt_d;
  logic [RW:0]        cnt_inc;

  mix_stage #(
    .LANES (LANES),
    .W     (W),
    .SHA   (SHA),
    .SHB   (SHB)
  ) u_stage (
    .lanes_in  (lanes_q),
    .stage     (stage_q),
    .lanes_out (mixed)
  );

  // One extra bit so R = 2^RW-1 compares correctly without wrapping.
  assign cnt_inc = {1'b0, cnt_q} + (RW+1)'(1);

  // State, lane, stage and round registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stage_q  <= S0;
      lanes_q  <= '0;
      rounds_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      lanes_q  <= lanes_d;
      rounds_q <= rounds_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: load on accept, step one stage per RUN cycle, hold through DONE.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    lanes_d  = lanes_q;
    rounds_d = rounds_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lanes_d  = in_seed;
          rounds_d = in_rounds;
          cnt_d    = '0;
          stage_d  = S0;
          state_d  = (in_rounds == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        lanes_d = mixed;
        if (stage_q == S6) begin
          stage_d = S0;
          cnt_d   = cnt_inc[RW-1:0];
          if (cnt_inc == {1'b0, rounds_q}) begin
            state_d = DONE;
          end
        end else begin
          stage_d = stage_e'(stage_q + 3'd1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_data  = lanes_q;
  assign round_cnt = cnt_q;

endmodule
